reg_file: RTL
=============

# reg_file

Two-read, one-write register file for the ARM-style datapath, built as an array of enabled D flip-flop words; it consumes the single-bit flop storage primitive and feeds operands to the ALU/execute stage. It holds `NUM_REGS` words of `DATA_W` bits. It performs one synchronous write per cycle and provides two combinational reads. The highest-numbered register is hardwired to zero (XZR).

## Interface
- `DATA_W`, 64, word width in bits
- `NUM_REGS`, 32, number of architectural registers (power of two)
- `ADDR_W`, 5, register address width; must equal log2(`NUM_REGS`)

- `clk`  input  1  single clock; all state updates on rising edge
- `reset`  input  1  asynchronous, active-low (0 = reset asserted)
- `reg_write`  input  1  write enable, sampled on rising `clk`
- `write_reg`  input  `ADDR_W`  destination register address
- `write_data`  input  `DATA_W`  data to write
- `read_reg1`  input  `ADDR_W`  port 1 source address
- `read_reg2`  input  `ADDR_W`  port 2 source address
- `read_data1`  output  `DATA_W`  port 1 data
- `read_data2`  output  `DATA_W`  port 2 data

## Operation
- Storage: registers 0..`NUM_REGS`-2 are writable. Register `NUM_REGS`-1 (X31) has no storage and always reads 0.
- Write rule:
  - On a rising `clk` with `reset`=1 and `reg_write`=1, register[`write_reg`] <= `write_data`.
  - All other registers hold their values.
  - A write with `write_reg`=`NUM_REGS`-1 is discarded.
- `reg_write`=0: no register changes, regardless of `write_reg`/`write_data`.
- Read rule: `read_dataN` = register[`read_regN`], combinational. If `read_regN`=`NUM_REGS`-1, the output is 0.
- Both read ports are independent. The same address on both ports returns identical data.
- Reset:
  - `reset`=0 immediately clears every register to 0, without waiting for a clock edge.
  - Both outputs read 0 for any address while reset is held.
  - Reset overrides a coincident write.
  - Releasing `reset` does not cause a write; the first write can occur on the first rising edge with `reset`=1.
- Decode: one-hot write-enable decode of `write_reg` gated by `reg_write`. Read-out uses `NUM_REGS`:1 muxes, one per port.

## Timing
- Write latency:
  - Data written at rising edge k is visible on a read port immediately after edge k.
  - It is visible combinationally for the whole of cycle k+1.
- Read latency: 0 cycles (combinational from `read_regN` and register state).
- Same-cycle read of the register being written (read address = `write_reg`, `reg_write`=1, before the edge): see Configuration.
- Back-to-back writes to the same register on consecutive edges: the last write wins. Each intermediate value is readable for exactly one cycle.
- Async reset assertion mid-cycle: outputs go to 0 within combinational delay. A write pending for the next edge is lost if `reset` is still 0 at that edge.

## Configuration
- Macro: `REG_FILE_BYPASS_EN`
- Defined: write-through bypass for each read port.
  - Condition: `reg_write`=1, `reset`=1, and `read_regN`=`write_reg`≠`NUM_REGS`-1.
  - Under that condition, `read_dataN` = `write_data` in the same cycle, before the edge.
  - X31 still reads 0.
  - Used by the pipelined datapath to remove the WB→ID hazard.
- Not defined: reads always return stored state. A same-cycle read of the register being written returns the old value until after the edge.

## Test plan
- Reset: hold `reset`=0 with `reg_write`=1, `write_reg`=3, `write_data`=0xDEAD across 2 edges -> `read_data1`(addr 3)=0. Release reset, then read all 32 addresses -> all 0.
- Write/read all: for i=0..30, write 0x1000+i to register i on successive edges, then read i on port 1 and 30-i on port 2 -> values 0x1000+i and 0x1000+(30-i).
- XZR: write 0xFFFF_FFFF_FFFF_FFFF to register 31 -> both ports read 0 at addr 31. Registers 0..30 are unchanged.
- Write disabled: `reg_write`=0, `write_reg`=5, `write_data`=0x55 for 3 edges -> register 5 keeps its prior value (0x1005).
- Bypass: register 7=0x1007, then drive `reg_write`=1, `write_reg`=7, `write_data`=0xABCD, `read_reg1`=7 before the edge.
  - With `REG_FILE_BYPASS_EN`: `read_data1`=0xABCD.
  - Without: `read_data1`=0x1007.
  - In both builds, after the edge: 0xABCD.
- Async reset mid-cycle: with register 2=0x22, pull `reset` low between edges -> `read_data2`(addr 2)=0 before the next edge. It stays 0 after reset is released.

Source files
------------

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// Two-read, one-write register file for the execute-stage operand path.
// NUM_REGS words of DATA_W bits. The highest-numbered register (XZR) has no
// storage and always reads zero. One synchronous write per rising clk; two
// independent combinational read ports.
//
// Optional feature macro: REG_FILE_BYPASS_EN
//   defined   : a read of the register being written this cycle returns
//               write_data before the edge (write-through bypass).
//   undefined : reads always return stored state.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-low reset (clears all registers)
//   reg_write   in   write enable
//   write_reg   in   [ADDR_W-1:0] destination address
//   write_data  in   [DATA_W-1:0] write data
//   read_reg1   in   [ADDR_W-1:0] port 1 source address
//   read_reg2   in   [ADDR_W-1:0] port 2 source address
//   read_data1  out  [DATA_W-1:0] port 1 data (combinational)
//   read_data2  out  [DATA_W-1:0] port 2 data (combinational)
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int unsigned    NUM_STORED = NUM_REGS - 1;
    localparam logic [ADDR_W-1:0] ZR_ADDR = ADDR_W'(NUM_REGS - 1);

    // Storage for the writable registers only; XZR is never stored.
    logic [DATA_W-1:0] r_mem   [NUM_STORED];
    // Full read view: stored words plus a constant-zero XZR slot.
    logic [DATA_W-1:0] w_words [NUM_REGS];
    // One-hot write enables, one per stored register.
    logic [NUM_STORED-1:0] w_we;

    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // Write decode: an XZR address matches no stored word, so it is dropped.
    genvar gi;
    generate
        for (gi = 0; gi < int'(NUM_STORED); gi++) begin : g_dec
            assign w_we[gi]    = reg_write && (write_reg == ADDR_W'(gi));
            assign w_words[gi] = r_mem[gi];
        end
    endgenerate

    assign w_words[NUM_REGS-1] = '0;

    // Enabled D-flop words with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_STORED); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_STORED); i++) begin
                if (w_we[i]) begin
                    r_mem[i] <= write_data;
                end
            end
        end
    end

    // NUM_REGS:1 read muxes, one per port.
    assign w_rd1 = w_words[read_reg1];
    assign w_rd2 = w_words[read_reg2];

`ifdef REG_FILE_BYPASS_EN
    logic w_byp1;
    logic w_byp2;

    // Forward the in-flight write; never for XZR and never while in reset.
    assign w_byp1 = reg_write && reset && (write_reg != ZR_ADDR)
                    && (read_reg1 == write_reg);
    assign w_byp2 = reg_write && reset && (write_reg != ZR_ADDR)
                    && (read_reg2 == write_reg);

    assign read_data1 = w_byp1 ? write_data : w_rd1;
    assign read_data2 = w_byp2 ? write_data : w_rd2;
`else
    logic w_unused_zr;

    assign w_unused_zr = (write_reg == ZR_ADDR);
    assign read_data1  = w_rd1;
    assign read_data2  = w_rd2;
`endif

endmodule
